// File: rtl/db_sense_detect.sv
// Daughterboard SENSE probe: drive high/release/sample, then drive low/release/sample.
// Classifies the pin response and debounces it over consecutive scans into present/fault status.
module db_sense_detect #(
    parameter int DRIVE_CYCLES  = 16,
    parameter int SETTLE_CYCLES = 64,
    parameter int SCAN_INTERVAL = 100000,
    parameter int DEBOUNCE      = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sense_i,
    output logic sense_o,
    output logic sense_oe_o,
    input  logic scan_i,
    output logic busy_o,
    output logic present_o,
    output logic fault_o,
    output logic valid_o,
    output logic change_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_DRIVE_HI, S_SETTLE_HI, S_DRIVE_LO, S_SETTLE_LO, S_DECIDE
    } state_t;

    typedef enum logic [1:0] {
        C_ABSENT = 2'd0, C_PRESENT = 2'd1, C_FAULT = 2'd2
    } cls_t;

    localparam int PMAX = (DRIVE_CYCLES > SETTLE_CYCLES) ? DRIVE_CYCLES : SETTLE_CYCLES;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int IW   = (SCAN_INTERVAL > 0) ? $clog2(SCAN_INTERVAL + 1) : 1;
    localparam int DW   = $clog2(DEBOUNCE + 1);

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_cnt;
    logic [IW-1:0]   r_ivl;
    logic            r_first;
    logic [1:0]      r_sync;
    logic            r_s_hi, r_s_lo;
    cls_t            r_cand, r_cur, w_cls, w_cand_nxt;
    logic [DW-1:0]   r_dcnt, w_dcnt_nxt;
    logic            r_valid, r_present, r_fault, r_change;
    logic            r_oe, r_out, r_busy;
    logic            w_oe_nxt, w_out_nxt, w_busy_nxt;
    logic            w_start, w_drive_done, w_settle_done, w_update;

    assign w_drive_done  = (r_cnt == PW'(DRIVE_CYCLES - 1));
    assign w_settle_done = (r_cnt == PW'(SETTLE_CYCLES - 1));
    // First idle cycle after reset always launches a scan so detection needs no request.
    assign w_start = r_first || scan_i ||
                     ((SCAN_INTERVAL != 0) && (r_ivl == IW'(SCAN_INTERVAL)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_start)       w_state_nxt = S_DRIVE_HI;
            S_DRIVE_HI:  if (w_drive_done)  w_state_nxt = S_SETTLE_HI;
            S_SETTLE_HI: if (w_settle_done) w_state_nxt = S_DRIVE_LO;
            S_DRIVE_LO:  if (w_drive_done)  w_state_nxt = S_SETTLE_LO;
            S_SETTLE_LO: if (w_settle_done) w_state_nxt = S_DECIDE;
            default:                        w_state_nxt = S_IDLE;
        endcase
    end

    // Pad controls are decoded from the next state and registered, so they never glitch.
    always_comb begin
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_oe_nxt   = (w_state_nxt == S_DRIVE_HI) || (w_state_nxt == S_DRIVE_LO);
        w_out_nxt  = (w_state_nxt == S_DRIVE_HI);
    end

    always_comb begin
        case ({r_s_hi, r_s_lo})
            2'b00:   w_cls = C_PRESENT;
            2'b11:   w_cls = C_ABSENT;
            default: w_cls = C_FAULT;
        endcase
        w_cand_nxt = w_cls;
        w_dcnt_nxt = DW'(1);
        if (w_cls == r_cand) begin
            w_cand_nxt = r_cand;
            w_dcnt_nxt = (r_dcnt == DW'(DEBOUNCE)) ? r_dcnt : r_dcnt + DW'(1);
        end
        w_update = (w_dcnt_nxt == DW'(DEBOUNCE)) && (!r_valid || (w_cand_nxt != r_cur));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_ivl     <= '0;
            r_first   <= 1'b1;
            r_sync    <= 2'b00;
            r_s_hi    <= 1'b0;
            r_s_lo    <= 1'b0;
            r_cand    <= C_ABSENT;
            r_cur     <= C_ABSENT;
            r_dcnt    <= '0;
            r_valid   <= 1'b0;
            r_present <= 1'b0;
            r_fault   <= 1'b0;
            r_change  <= 1'b0;
            r_oe      <= 1'b0;
            r_out     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_first  <= 1'b0;
            r_sync   <= {r_sync[0], sense_i};
            r_oe     <= w_oe_nxt;
            r_out    <= w_out_nxt;
            r_busy   <= w_busy_nxt;
            r_change <= 1'b0;
            r_cnt    <= ((w_state_nxt != r_state) || (r_state == S_IDLE)) ? '0 : r_cnt + PW'(1);
            if (r_state == S_DECIDE) begin
                r_ivl <= '0;
            end else if ((r_state == S_IDLE) && (r_ivl != IW'(SCAN_INTERVAL))) begin
                r_ivl <= r_ivl + IW'(1);
            end
            if ((r_state == S_SETTLE_HI) && w_settle_done) r_s_hi <= r_sync[1];
            if ((r_state == S_SETTLE_LO) && w_settle_done) r_s_lo <= r_sync[1];
            if (r_state == S_DECIDE) begin
                r_cand <= w_cand_nxt;
                r_dcnt <= w_dcnt_nxt;
                if (w_update) begin
                    r_cur     <= w_cand_nxt;
                    r_valid   <= 1'b1;
                    r_present <= (w_cand_nxt == C_PRESENT);
                    r_fault   <= (w_cand_nxt == C_FAULT);
                    r_change  <= 1'b1;
                end
            end
        end
    end

    assign sense_o    = r_out;
    assign sense_oe_o = r_oe;
    assign busy_o     = r_busy;
    assign present_o  = r_present;
    assign fault_o    = r_fault;
    assign valid_o    = r_valid;
    assign change_o   = r_change;
endmodule

// File: tb/tb_db_sense_detect.sv
// Bench for db_sense_detect: pin resistor/keeper model, per-scan measurement and a debounce reference model.
module tb_db_sense_detect;
    localparam int DRV = 16, STL = 64, IVL = 200, DEB = 3;
    localparam int SCAN_LEN = 2*DRV + 2*STL + 1;
    localparam int M_PD = 0, M_PU = 1, M_FLOAT = 2, M_INV = 3;
    localparam int C_ABS = 0, C_PRES = 1, C_FLT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sense_in, sense_out, sense_oe, scan, busy, present, fault, valid, change;
    logic sense0_in, sense0_out, sense0_oe, scan0, busy0, present0, fault0, valid0, change0;
    logic keeper = 1'b0;
    int   pin_mode = M_PD;
    int   checks = 0, failures = 0;
    int   exp_cls;
    bit   exp_valid, exp_chg;
    int   hist[$];

    always #5 clk = ~clk;

    // Released pin: pull-down, pull-up, bus keeper, or a broken net reading the inverse of the keeper.
    always @(posedge clk) if (sense_oe) keeper <= sense_out;
    assign sense_in  = sense_oe ? sense_out :
                       (pin_mode == M_PD) ? 1'b0 :
                       (pin_mode == M_PU) ? 1'b1 :
                       (pin_mode == M_FLOAT) ? keeper : ~keeper;
    assign sense0_in = sense0_oe ? sense0_out : 1'b0;

    db_sense_detect #(.DRIVE_CYCLES(DRV), .SETTLE_CYCLES(STL), .SCAN_INTERVAL(IVL), .DEBOUNCE(DEB)) dut (
        .clk_i(clk), .rst_i(rst), .sense_i(sense_in), .sense_o(sense_out), .sense_oe_o(sense_oe),
        .scan_i(scan), .busy_o(busy), .present_o(present), .fault_o(fault), .valid_o(valid),
        .change_o(change));

    db_sense_detect #(.DRIVE_CYCLES(DRV), .SETTLE_CYCLES(STL), .SCAN_INTERVAL(0), .DEBOUNCE(DEB)) dut0 (
        .clk_i(clk), .rst_i(rst), .sense_i(sense0_in), .sense_o(sense0_out), .sense_oe_o(sense0_oe),
        .scan_i(scan0), .busy_o(busy0), .present_o(present0), .fault_o(fault0), .valid_o(valid0),
        .change_o(change0));

    task automatic model_reset();
        hist.delete();
        exp_valid = 1'b0;
        exp_cls   = C_ABS;
        exp_chg   = 1'b0;
    endtask

    // Outputs move when the last DEB scan results agree and differ from what is shown (or nothing is shown yet).
    task automatic model_step(input int m);
        int c;
        bit same;
        c = (m == M_PD) ? C_PRES : (m == M_PU) ? C_ABS : C_FLT;
        hist.push_back(c);
        if (hist.size() > DEB) void'(hist.pop_front());
        exp_chg = 1'b0;
        if (hist.size() == DEB) begin
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != c) same = 1'b0;
            if (same && (!exp_valid || c != exp_cls)) begin
                exp_cls = c; exp_valid = 1'b1; exp_chg = 1'b1;
            end
        end
    endtask

    function automatic logic [2:0] exp_outs();
        return {exp_valid && exp_cls == C_PRES, exp_valid && exp_cls == C_FLT, exp_valid};
    endfunction

    // Runs one scan with the given pin behaviour and measures it; ends on the first idle cycle.
    task automatic run_scan(input int m, output int blen, output int oelen, output int chg,
                            output int bad, output int gap, output bit tmo);
        int n;
        blen = 0; oelen = 0; chg = 0; bad = 0; gap = 0; tmo = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin @(negedge clk); n++; end
        pin_mode = m;
        while (busy !== 1'b1 && gap < 2000) begin
            @(negedge clk); gap++;
            if (change === 1'b1) chg++;
        end
        if (busy !== 1'b1) begin tmo = 1'b1; return; end
        while (busy === 1'b1 && blen < 2000) begin
            blen++;
            if (sense_oe === 1'b1) oelen++;
            if (sense_oe !== 1'b1 && sense_out !== 1'b0) bad++;
            if (change === 1'b1) chg++;
            @(negedge clk);
        end
        if (change === 1'b1) chg++;
        model_step(m);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({sense_oe, sense_out, busy, present, fault, valid, change} !== 7'b0) begin
            failures++; $display("FAIL reset_outputs: got %b expected 0000000",
                {sense_oe, sense_out, busy, present, fault, valid, change});
        end
        checks++;
        if ({sense0_oe, sense0_out, busy0, present0, fault0, valid0, change0} !== 7'b0) begin
            failures++; $display("FAIL reset_outputs_dut0: got %b expected 0000000",
                {sense0_oe, sense0_out, busy0, present0, fault0, valid0, change0});
        end
    endtask

    task automatic test_present();
        int blen, oelen, chg, bad, gap;
        bit tmo;
        model_reset();
        pin_mode = M_PD;
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            run_scan(M_PD, blen, oelen, chg, bad, gap, tmo);
            checks++;
            if (tmo || blen != SCAN_LEN) begin failures++;
                $display("FAIL present_busy_len scan%0d: got %0d (timeout %0d) expected %0d", s, blen, tmo, SCAN_LEN); end
            checks++;
            if (chg != int'(exp_chg)) begin failures++;
                $display("FAIL present_change scan%0d: got %0d pulses expected %0d", s, chg, exp_chg); end
            checks++;
            if ({present, fault, valid} !== exp_outs()) begin failures++;
                $display("FAIL present_outs scan%0d: got %b expected %b", s, {present, fault, valid}, exp_outs()); end
            if (s > 0) begin
                checks++;
                if (gap != IVL + 1) begin failures++;
                    $display("FAIL interval_gap scan%0d: got %0d expected %0d", s, gap, IVL + 1); end
            end
        end
    endtask

    task automatic test_toggle();
        int blen, oelen, chg, bad, gap;
        bit tmo;
        int seq[5] = '{M_PU, M_PD, M_PU, M_PU, M_PU};
        for (int s = 0; s < 5; s++) begin
            run_scan(seq[s], blen, oelen, chg, bad, gap, tmo);
            checks++;
            if (tmo || chg != int'(exp_chg)) begin failures++;
                $display("FAIL toggle_change scan%0d: got %0d pulses (timeout %0d) expected %0d", s, chg, tmo, exp_chg); end
            checks++;
            if ({present, fault, valid} !== exp_outs()) begin failures++;
                $display("FAIL toggle_outs scan%0d: got %b expected %b", s, {present, fault, valid}, exp_outs()); end
        end
    endtask

    task automatic test_absent_from_reset();
        int blen, oelen, chg, bad, gap;
        bit tmo;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        checks++;
        if ({sense_oe, busy, present, fault, valid} !== 5'b0) begin failures++;
            $display("FAIL rereset_outputs: got %b expected 00000", {sense_oe, busy, present, fault, valid}); end
        pin_mode = M_PU;
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            run_scan(M_PU, blen, oelen, chg, bad, gap, tmo);
            checks++;
            if (tmo || oelen != 2*DRV || bad != 0) begin failures++;
                $display("FAIL absent_drive scan%0d: got oe=%0d bad=%0d (timeout %0d) expected oe=%0d bad=0", s, oelen, bad, tmo, 2*DRV); end
            checks++;
            if (chg != int'(exp_chg)) begin failures++;
                $display("FAIL absent_change scan%0d: got %0d expected %0d", s, chg, exp_chg); end
            checks++;
            if ({present, fault, valid} !== exp_outs()) begin failures++;
                $display("FAIL absent_outs scan%0d: got %b expected %b", s, {present, fault, valid}, exp_outs()); end
        end
    endtask

    task automatic test_float();
        int blen, oelen, chg, bad, gap;
        bit tmo;
        for (int s = 0; s < 3; s++) begin
            run_scan(M_FLOAT, blen, oelen, chg, bad, gap, tmo);
            checks++;
            if (tmo || chg != int'(exp_chg) || {present, fault, valid} !== exp_outs()) begin failures++;
                $display("FAIL float scan%0d: got chg=%0d outs=%b expected chg=%0d outs=%b", s, chg,
                    {present, fault, valid}, exp_chg, exp_outs()); end
        end
    endtask

    task automatic test_random();
        int blen, oelen, chg, bad, gap;
        bit tmo;
        int m = M_PD;
        for (int s = 0; s < 15; s++) begin
            if ($urandom_range(0, 2) == 0) m = int'($urandom_range(0, 3));
            run_scan(m, blen, oelen, chg, bad, gap, tmo);
            checks++;
            if (tmo || blen != SCAN_LEN || chg != int'(exp_chg) || {present, fault, valid} !== exp_outs()) begin failures++;
                $display("FAIL random scan%0d mode%0d: got len=%0d chg=%0d outs=%b expected len=%0d chg=%0d outs=%b",
                    s, m, blen, chg, {present, fault, valid}, SCAN_LEN, exp_chg, exp_outs()); end
        end
    endtask

    task automatic test_reset_midscan();
        int n = 0;
        while (!(busy === 1'b1 && sense_oe === 1'b1 && sense_out === 1'b1) && n < 2000) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        checks++;
        if ({sense_oe, sense_out, busy, present, fault, valid, change} !== 7'b0) begin failures++;
            $display("FAIL midscan_reset: got %b expected 0000000",
                {sense_oe, sense_out, busy, present, fault, valid, change}); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, sense_oe, sense_out} !== 3'b111) begin failures++;
            $display("FAIL midscan_restart: got busy/oe/o=%b expected 111", {busy, sense_oe, sense_out}); end
    endtask

    task automatic test_manual_scan();
        int n = 0, hi = 0, rises = 0;
        logic prev = 1'b0;
        while (busy0 === 1'b1 && n < 2000) begin @(negedge clk); n++; end
        for (int c = 0; c < 600; c++) begin @(negedge clk); if (busy0 !== 1'b0) rises++; end
        checks++;
        if (rises != 0) begin failures++;
            $display("FAIL noauto_scan: got %0d busy cycles expected 0", rises); end
        rises = 0;
        for (int c = 0; c < 400; c++) begin
            scan0 = (c == 0 || c == 10);
            @(negedge clk);
            if (busy0 === 1'b1) hi++;
            if (busy0 === 1'b1 && prev !== 1'b1) rises++;
            prev = busy0;
        end
        scan0 = 1'b0;
        checks++;
        if (hi != SCAN_LEN || rises != 1) begin failures++;
            $display("FAIL manual_scan: got busy=%0d scans=%0d expected busy=%0d scans=1", hi, rises, SCAN_LEN); end
    endtask

    initial begin
        scan = 1'b0;
        scan0 = 1'b0;
        test_reset();
        test_present();
        test_toggle();
        test_absent_from_reset();
        test_float();
        test_random();
        test_reset_midscan();
        test_manual_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
